pkt_tx_sched: RTL and testbench
===============================

// Module: pkt_tx_sched
// PURPOSE
//   Round-robin scheduler/serialiser for the shared single-wire packet bus that feeds the rx input of pctrl.
//   NREQ local requesters each present a packet: 8-bit address, 3-bit opcode and 62-bit data.
//   Grants one requester at a time and shifts its frame onto tx, one bit per clk.
//   Enforces GAP idle-high cycles between frames so downstream receivers resynchronise.
// PARAMETERS
//   NREQ  4  number of requesters, legal range 1..8
//   GAP   4  idle cycles (tx=1) after each frame, legal range 0..255
// PORTS
//   clk    in   1         system clock; all state on rising edge
//   nRst   in   1         reset, asynchronous, active-high (1 = in reset)
//   req    in   NREQ      req[i]=1: requester i has a packet ready
//   addr   in   NREQ*8    addr[i*8+:8] target address of requester i
//   op     in   NREQ*3    op[i*3+:3] opcode of requester i
//   data   in   NREQ*62   data[i*62+:62] payload of requester i
//   grant  out  NREQ      one-hot, 1-cycle pulse: requester i's packet captured
//   busy   out  1         1 while state != IDLE
//   done   out  1         1-cycle pulse while tx carries the final frame bit
//   tx     out  1         serial bus; idles high
// BEHAVIOUR
//   Reset (async, while nRst=1):
//     tx=1, grant=0, busy=0, done=0, state=IDLE, bit counter=0, rr pointer=NREQ-1.
//   Frame is 74 bits, all fields MSB first:
//     start bit 0, then addr[7:0], op[2:0], data[61:0].
//   All outputs are registered.
//   States:
//     IDLE -> SEND: on an edge with any req bit high.
//       Same edge: winner's fields loaded into the 74-bit shift register.
//       grant[w]=1 and tx=0 (start bit) in the following cycle t0.
//     SEND: tx shows frame bit k in cycle t0+k, k=0..73.
//       done=1 in cycle t0+73.
//       If GAP=0 -> IDLE after t0+73; otherwise -> GAP.
//     GAP: tx=1 for cycles t0+74..t0+73+GAP, then -> IDLE.
//   busy: 1 from t0 through the last GAP cycle. done and grant occur only with busy=1.
//   Arbitration: search starts at rr_pointer+1 mod NREQ; first req set wins.
//     rr_pointer <= winner on grant. After reset, req[0] has top priority.
//   req is sampled only in IDLE; changes during SEND/GAP are ignored.
//     Requester may hold req high to queue its next packet.
//     Operands must be stable only in the IDLE cycle when req is sampled.
//     Captured data is unaffected by later operand changes.
//   Back-to-back: a req still high gives the next start bit at t0+75+GAP.
//   No req in IDLE: tx stays 1, no pulses, state holds.
//   Reset mid-frame: tx=1 immediately (async), frame aborted, no done.
//     rr pointer returns to NREQ-1.
//     Requesters re-request; the aborted frame is not replayed.
//   NREQ=1: grant[0] whenever req[0] and IDLE; the arbiter degenerates cleanly.
// TESTING
//   1. req[0]=1, addr0=8'hAA, op0=3'h4, data0=62'd100:
//      tx = 0,10101010,100,{55 zeros}1100100.
//      grant[0] pulses once at t0; done at t0+73.
//      A pctrl instance at address 8'hAA decodes opcode 4.
//   2. req=4'b0011 asserted together after reset, held until each grant:
//      requester 0 first, requester 1 next, start bits 75+GAP cycles apart.
//   3. req=4'b1111 held constantly:
//      grant order 0,1,2,3,0,1; each grant exactly one cycle, never two bits set.
//   4. nRst=1 during frame bit 30:
//      tx=1, busy=0, grant=0 at once; no done.
//      After release with req=4'b0100, tx stays 1 until the new grant.
//      New frame is complete and correct, with requester 2 granted first.
//   5. No requests for 1000 cycles: tx=1, busy=0, grant=0, done=0 throughout.
//   6. GAP=0 build, req[3] held:
//      consecutive start bits 75 cycles apart; tx=1 in exactly one cycle between frames.
//      Operand change during SEND is not reflected in the current frame.

Source files
------------

// File: rtl/pkt_tx_sched_if.sv
// rtl/pkt_tx_sched_if.sv - requester handshake and serial bus bundle for pkt_tx_sched
interface pkt_tx_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*8-1:0]  addr;
    logic [NREQ*3-1:0]  op;
    logic [NREQ*62-1:0] data;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic               done;
    logic               tx;

    modport master (
        output req, addr, op, data,
        input  grant, busy, done, tx
    );

    modport slave (
        input  req, addr, op, data,
        output grant, busy, done, tx
    );
endinterface

// File: rtl/pkt_tx_sched.sv
// rtl/pkt_tx_sched.sv - round-robin packet scheduler serialising 74-bit frames onto tx
module pkt_tx_sched #(
    parameter int NREQ = 4,
    parameter int GAP  = 4
) (
    input  logic           clk,
    input  logic           nRst,
    pkt_tx_sched_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int FW = 74;

    typedef enum logic [1:0] {IDLE, SEND, GAPS} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   shreg_q, shreg_d;
    logic [6:0]      bit_q, bit_d;
    logic [7:0]      gap_q, gap_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            found;
    logic [PW-1:0]   win;
    logic [FW-1:0]   win_frame;

    // Two passes give rotating priority: indices above the pointer first, then the wrap-around.
    always_comb begin
        found     = 1'b0;
        win       = '0;
        win_frame = '1;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req[j] && (j > int'(rr_q))) begin
                found     = 1'b1;
                win       = PW'(j);
                win_frame = {1'b0, bus.addr[j*8 +: 8], bus.op[j*3 +: 3], bus.data[j*62 +: 62]};
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req[j] && (j <= int'(rr_q))) begin
                found     = 1'b1;
                win       = PW'(j);
                win_frame = {1'b0, bus.addr[j*8 +: 8], bus.op[j*3 +: 3], bus.data[j*62 +: 62]};
            end
        end
    end

    // The shift register's MSB is tx itself; it is refilled with ones outside a frame so the bus idles high.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        rr_d    = rr_q;
        grant_d = '0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                shreg_d = '1;
                busy_d  = 1'b0;
                if (found) begin
                    state_d = SEND;
                    shreg_d = win_frame;
                    grant_d = NREQ'(1) << win;
                    rr_d    = win;
                    bit_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SEND: begin
                if (bit_q == 7'd73) begin
                    shreg_d = '1;
                    if (GAP == 0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = GAPS;
                        gap_d   = '0;
                    end
                end else begin
                    shreg_d = {shreg_q[FW-2:0], 1'b1};
                    bit_d   = bit_q + 7'd1;
                    done_d  = (bit_q == 7'd72);
                end
            end
            GAPS: begin
                shreg_d = '1;
                if (gap_q == 8'(GAP - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                shreg_d = '1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            state_q <= IDLE;
            shreg_q <= '1;
            bit_q   <= '0;
            gap_q   <= '0;
            rr_q    <= PW'(NREQ - 1);
            grant_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx    = shreg_q[FW-1];
    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_pkt_tx_sched.sv
// tb/tb_pkt_tx_sched.sv - randomized and directed bench for pkt_tx_sched with a behavioural frame model
module tb_pkt_tx_sched;
    localparam int NREQ = 4;
    localparam int GAP  = 4;

    logic clk  = 1'b0;
    logic nRst = 1'b1;
    always #5 clk = ~clk;

    pkt_tx_sched_if #(.NREQ(NREQ)) b4 ();
    pkt_tx_sched_if #(.NREQ(NREQ)) b0 ();

    pkt_tx_sched #(.NREQ(NREQ), .GAP(GAP)) dut  (.clk(clk), .nRst(nRst), .bus(b4.slave));
    pkt_tx_sched #(.NREQ(NREQ), .GAP(0))   dut0 (.clk(clk), .nRst(nRst), .bus(b0.slave));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: phase = cycles since the start bit of the current frame, -1 when idle.
    int          m_phase [2];
    int          m_rr    [2];
    int          m_win   [2];
    logic [73:0] m_frame [2];
    int          m_gap   [2];

    initial begin
        m_gap[0] = GAP;
        m_gap[1] = 0;
    end

    task automatic m_step(input int d, input logic [NREQ-1:0] r, input logic [NREQ*8-1:0] a,
                          input logic [NREQ*3-1:0] o, input logic [NREQ*62-1:0] dt);
        if (m_phase[d] < 0) begin
            if (r != '0) begin
                for (int i = 1; i <= NREQ; i++) begin
                    int c;
                    c = (m_rr[d] + i) % NREQ;
                    if (r[c]) begin
                        m_win[d]   = c;
                        m_rr[d]    = c;
                        m_frame[d] = {1'b0, a[c*8 +: 8], o[c*3 +: 3], dt[c*62 +: 62]};
                        m_phase[d] = 0;
                        break;
                    end
                end
            end
        end else begin
            m_phase[d]++;
            if (m_phase[d] == 74 + m_gap[d]) m_phase[d] = -1;
        end
    endtask

    always @(posedge clk or posedge nRst) begin
        if (nRst) begin
            for (int d = 0; d < 2; d++) begin
                m_phase[d] = -1;
                m_rr[d]    = NREQ - 1;
            end
        end else begin
            m_step(0, b4.req, b4.addr, b4.op, b4.data);
            m_step(1, b0.req, b0.addr, b0.op, b0.data);
            cyc++;
        end
    end

    task automatic check_dut(input int d, input logic tx, input logic busy, input logic done,
                             input logic [NREQ-1:0] grant);
        logic            e_tx, e_busy, e_done;
        logic [NREQ-1:0] e_grant;
        int              p;
        p       = m_phase[d];
        e_busy  = (p >= 0);
        e_tx    = (p >= 0 && p <= 73) ? m_frame[d][73-p] : 1'b1;
        e_done  = (p == 73);
        e_grant = (p == 0) ? (NREQ'(1) << m_win[d]) : '0;
        n_checks++;
        if ({tx, busy, done, grant} !== {e_tx, e_busy, e_done, e_grant}) begin
            n_fail++;
            $display("FAIL cycle_compare dut%0d cyc=%0d got tx=%b busy=%b done=%b grant=%b expected tx=%b busy=%b done=%b grant=%b",
                     d, cyc, tx, busy, done, grant, e_tx, e_busy, e_done, e_grant);
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, b4.tx, b4.busy, b4.done, b4.grant);
        check_dut(1, b0.tx, b0.busy, b0.done, b0.grant);
    end

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_grant(input string name, input int d, output int idx, output int at);
        logic [NREQ-1:0] g;
        bit seen;
        seen = 1'b0;
        idx  = -1;
        at   = -1;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            g = (d == 0) ? b4.grant : b0.grant;
            if (g != '0) begin
                seen = 1'b1;
                at   = cyc;
                for (int j = 0; j < NREQ; j++) if (g[j]) idx = j;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: got no grant expected a grant within 400 cycles", name);
        end
    endtask

    // Called on the t0 negedge; collects the 74 frame bits and where done fired.
    task automatic cap_frame(input int d, output logic [73:0] f, output int done_k, output int done_n);
        done_k = -1;
        done_n = 0;
        for (int k = 0; k < 74; k++) begin
            if (k > 0) @(negedge clk);
            f[73-k] = (d == 0) ? b4.tx : b0.tx;
            if ((d == 0) ? b4.done : b0.done) begin
                done_k = k;
                done_n++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        nRst = 1'b1;
        repeat (2) @(negedge clk);
        nRst = 1'b0;
    endtask

    task automatic randomize_ops();
        for (int j = 0; j < NREQ; j++) begin
            b4.addr[j*8 +: 8]   = 8'($urandom);
            b4.op[j*3 +: 3]     = 3'($urandom);
            b4.data[j*62 +: 62] = 62'({$urandom, $urandom});
            b0.addr[j*8 +: 8]   = 8'($urandom);
            b0.op[j*3 +: 3]     = 3'($urandom);
            b0.data[j*62 +: 62] = 62'({$urandom, $urandom});
        end
    endtask

    initial begin
        int          idx, at, idx2, at2, dk, dn, bad, low;
        logic [73:0] f;
        int          order [6];
        int          times [6];
        int          exp_order [6];

        b4.req = '0; b4.addr = '0; b4.op = '0; b4.data = '0;
        b0.req = '0; b0.addr = '0; b0.op = '0; b0.data = '0;
        repeat (2) @(negedge clk);
        chk("rst_tx",    b4.tx, 1);
        chk("rst_busy",  b4.busy, 0);
        chk("rst_grant", b4.grant, 0);
        chk("rst_done",  b4.done, 0);
        nRst = 1'b0;

        // Single packet to address AA, opcode 4, payload 100.
        b4.addr[7:0] = 8'hAA; b4.op[2:0] = 3'h4; b4.data[61:0] = 62'd100;
        b4.req = 4'b0001;
        wait_grant("t1", 0, idx, at);
        b4.req = '0;
        cap_frame(0, f, dk, dn);
        chk("t1_grant_idx", idx, 0);
        chk("t1_frame", f, {12'h554, 62'd100});
        chk("t1_done_at", dk, 73);
        chk("t1_done_cnt", dn, 1);
        repeat (GAP + 3) @(negedge clk);

        // Two requesters together straight after reset.
        do_reset();
        randomize_ops();
        b4.req = 4'b0011;
        wait_grant("t2a", 0, idx, at);
        b4.req[idx] = 1'b0;
        wait_grant("t2b", 0, idx2, at2);
        b4.req[idx2] = 1'b0;
        chk("t2_first", idx, 0);
        chk("t2_second", idx2, 1);
        chk("t2_spacing", at2 - at, 75 + GAP);
        repeat (90) @(negedge clk);

        // All four held: strict rotation.
        do_reset();
        b4.req = 4'b1111;
        exp_order = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < 6; i++) wait_grant("t3", 0, order[i], times[i]);
        b4.req = '0;
        for (int i = 0; i < 6; i++) chk($sformatf("t3_order%0d", i), order[i], exp_order[i]);
        for (int i = 1; i < 6; i++) chk($sformatf("t3_spacing%0d", i), times[i] - times[i-1], 79);
        repeat (90) @(negedge clk);

        // Reset while frame bit 30 is on the wire.
        do_reset();
        randomize_ops();
        b4.req = 4'b0001;
        wait_grant("t4a", 0, idx, at);
        b4.req = '0;
        repeat (30) @(negedge clk);
        nRst = 1'b1;
        #1;
        chk("t4_rst_tx", b4.tx, 1);
        chk("t4_rst_busy", b4.busy, 0);
        chk("t4_rst_grant", b4.grant, 0);
        b4.req = 4'b0100;
        b4.addr[23:16] = 8'h3C; b4.op[8:6] = 3'h2; b4.data[185:124] = 62'h2AAA_5555_0F0F_1234;
        repeat (2) @(negedge clk);
        nRst = 1'b0;
        wait_grant("t4b", 0, idx, at);
        b4.req = '0;
        cap_frame(0, f, dk, dn);
        chk("t4_grant_idx", idx, 2);
        chk("t4_frame", f, {1'b0, 8'h3C, 3'h2, 62'h2AAA_5555_0F0F_1234});
        chk("t4_done_at", dk, 73);
        repeat (GAP + 3) @(negedge clk);

        // Quiet bus.
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (b4.tx !== 1'b1 || b4.busy !== 1'b0 || b4.grant !== '0 || b4.done !== 1'b0) bad++;
        end
        chk("t5_idle_violations", bad, 0);

        // GAP=0 instance, requester 3 held, operands changed mid-frame.
        b0.addr[31:24] = 8'h5A; b0.op[11:9] = 3'h7; b0.data[247:186] = 62'd1;
        b0.req = 4'b1000;
        wait_grant("t6a", 1, idx, at);
        b0.addr[31:24] = 8'hC3; b0.op[11:9] = 3'h1; b0.data[247:186] = 62'h3FFF_0000_FFFF_0000;
        cap_frame(1, f, dk, dn);
        chk("t6_grant_idx", idx, 3);
        chk("t6_frame", f, {1'b0, 8'h5A, 3'h7, 62'd1});
        low = 0;
        at2 = -1;
        for (int k = 0; k < 20 && at2 < 0; k++) begin
            @(negedge clk);
            if (b0.grant != '0) at2 = cyc;
            else if (b0.busy === 1'b0) low++;
        end
        b0.req = '0;
        chk("t6_spacing", at2 - at, 75);
        chk("t6_idle_between", low, 1);
        repeat (80) @(negedge clk);

        // Randomized traffic on both instances, with one reset in the middle.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            b4.req = NREQ'($urandom) & NREQ'($urandom);
            b0.req = NREQ'($urandom) & NREQ'($urandom);
            randomize_ops();
            if (i == 2017) nRst = 1'b1;
            if (i == 2019) nRst = 1'b0;
        end
        b4.req = '0;
        b0.req = '0;
        repeat (100) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
